// File: rtl/rbot_pkg.sv
// Shared cube-robot definitions: face and turn codes, the packed move word,
// and the sequencer state encoding.
package rbot_pkg;

  localparam logic [2:0] FACE_U = 3'd0;
  localparam logic [2:0] FACE_D = 3'd1;
  localparam logic [2:0] FACE_F = 3'd2;
  localparam logic [2:0] FACE_B = 3'd3;
  localparam logic [2:0] FACE_L = 3'd4;
  localparam logic [2:0] FACE_R = 3'd5;

  localparam logic [1:0] TURN_BAD  = 2'b00;
  localparam logic [1:0] TURN_CW   = 2'b01;
  localparam logic [1:0] TURN_HALF = 2'b10;
  localparam logic [1:0] TURN_CCW  = 2'b11;

  typedef struct packed {
    logic [2:0] face;
    logic [1:0] turn;
  } move_t;

  localparam int MOVE_W = $bits(move_t);

  typedef enum logic [2:0] {
    ST_IDLE, ST_DECODE, ST_START, ST_ACK, ST_RUN, ST_SETTLE
  } seq_state_e;

  function automatic logic move_ok(input move_t m);
    return (m.face <= FACE_R) && (m.turn != TURN_BAD);
  endfunction

endpackage

// File: rtl/move_fifo.sv
// Synchronous move FIFO; full is a flop so the upstream ready is registered.
// flush wins over a same-cycle push or pop.
module move_fifo
  import rbot_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = MOVE_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("move_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             push_ok, pop_ok;

  assign push_ok = push & ~full_q & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;
  assign empty   = (cnt_q == '0);
  assign full    = full_q;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
    full_d = (cnt_d == CNT_FULL);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/move_sequencer.sv
// Pops cube moves from the FIFO and runs them one at a time on the face
// stepper drivers: start pulse, accept handshake, wait done, settle gap.
module move_sequencer
  import rbot_pkg::*;
#(
  parameter int FIFO_DEPTH    = 16,
  parameter int STEPS_QUARTER = 50,
  parameter int GAP_CYCLES    = 1000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        move_valid,
  input  logic [4:0]  move_data,
  output logic        move_ready,
  input  logic        flush,
  input  logic [5:0]  motor_done,
  output logic [5:0]  motor_start,
  output logic [7:0]  motor_steps,
  output logic        motor_dir,
  output logic        busy,
  output logic        bad_move,
  output logic [15:0] moves_done
);

  if (STEPS_QUARTER < 1 || 2 * STEPS_QUARTER > 255) begin : g_bad_steps
    $error("move_sequencer: 2*STEPS_QUARTER must fit in 8 bits");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("move_sequencer: GAP_CYCLES must be >= 1");
  end

  localparam int         GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [7:0] STEPS_Q8 = 8'(STEPS_QUARTER);
  localparam logic [7:0] STEPS_H8 = 8'(2 * STEPS_QUARTER);

  seq_state_e        state_q, state_d;
  move_t             entry_q, entry_d;
  logic [2:0]        face_q, face_d;
  logic [7:0]        steps_q, steps_d;
  logic              dir_q, dir_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [15:0]       done_cnt_q, done_cnt_d;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic [MOVE_W-1:0] fifo_rdata;
  logic [5:0]        face_oh;
  logic              done_sel;

  move_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(MOVE_W)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (move_valid),
    .pop     (fifo_pop),
    .flush   (flush),
    .wdata   (move_data),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Masking instead of indexing keeps X on idle faces out of done_sel.
  assign face_oh  = 6'b000001 << face_q;
  assign done_sel = |(motor_done & face_oh);

  assign move_ready  = ~fifo_full;
  assign motor_steps = steps_q;
  assign motor_dir   = dir_q;
  assign moves_done  = done_cnt_q;
  assign busy        = ~fifo_empty | (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    face_d      = face_q;
    steps_d     = steps_q;
    dir_d       = dir_q;
    gap_d       = gap_q;
    done_cnt_d  = done_cnt_q;
    fifo_pop    = 1'b0;
    motor_start = '0;
    bad_move    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !flush) begin
          fifo_pop = 1'b1;
          entry_d  = move_t'(fifo_rdata);
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (move_ok(entry_q)) begin
          face_d  = entry_q.face;
          steps_d = (entry_q.turn == TURN_HALF) ? STEPS_H8 : STEPS_Q8;
          dir_d   = (entry_q.turn == TURN_CCW);
          state_d = ST_START;
        end else begin
          bad_move = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_START: begin
        motor_start = face_oh;
        state_d     = ST_ACK;
      end
      // done must drop first so a stale done from the previous move is not taken
      ST_ACK: if (!done_sel) state_d = ST_RUN;
      ST_RUN: begin
        if (done_sel) begin
          done_cnt_d = done_cnt_q + 16'd1;
          gap_d      = GW'(GAP_CYCLES - 1);
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      entry_q    <= '0;
      face_q     <= '0;
      steps_q    <= '0;
      dir_q      <= 1'b0;
      gap_q      <= '0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      face_q     <= face_d;
      steps_q    <= steps_d;
      dir_q      <= dir_d;
      gap_q      <= gap_d;
      done_cnt_q <= done_cnt_d;
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with a behavioural stepper-driver bank.
module tb_move_sequencer;

  localparam int GAP = 1000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        move_valid = 1'b0;
  logic [4:0]  move_data = '0;
  logic        flush = 1'b0;
  logic        move_ready;
  logic [5:0]  motor_done;
  logic [5:0]  motor_start;
  logic [7:0]  motor_steps;
  logic        motor_dir;
  logic        busy;
  logic        bad_move;
  logic [15:0] moves_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nstart = 0;

  always #5 clock = ~clock;

  move_sequencer #(.FIFO_DEPTH(16), .STEPS_QUARTER(50), .GAP_CYCLES(GAP)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .move_valid  (move_valid),
    .move_data   (move_data),
    .move_ready  (move_ready),
    .flush       (flush),
    .motor_done  (motor_done),
    .motor_start (motor_start),
    .motor_steps (motor_steps),
    .motor_dir   (motor_dir),
    .busy        (busy),
    .bad_move    (bad_move),
    .moves_done  (moves_done)
  );

  // Driver bank: done drops on start, rises one cycle after the steps run out.
  logic [5:0] drv_done = 6'h3f;
  int         drv_cnt [6] = '{0, 0, 0, 0, 0, 0};
  logic       stall = 1'b0;
  assign motor_done = drv_done;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (|motor_start) nstart <= nstart + 1;
    for (int f = 0; f < 6; f++) begin
      if (motor_start[f]) begin
        drv_done[f] <= 1'b0;
        drv_cnt[f]  <= int'(motor_steps);
      end else if (!drv_done[f] && !stall) begin
        if (drv_cnt[f] == 0) drv_done[f] <= 1'b1;
        else                 drv_cnt[f]  <= drv_cnt[f] - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; move_valid = 1'b0; flush = 1'b0; stall = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic push(input logic [4:0] d);
    move_valid = 1'b1; move_data = d;
    tick(1);
    move_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag, output int c);
    int n = 0;
    while (motor_start == '0 && n < 3000) begin tick(1); n++; end
    chk(tag, 32'(n < 3000), 32'd1);
    c = cyc;
  endtask

  task automatic wait_md(input string tag, input logic [15:0] v, output int c);
    int n = 0;
    while (moves_done != v && n < 3000) begin tick(1); n++; end
    chk(tag, 32'(moves_done), 32'(v));
    c = cyc;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 3000) begin tick(1); n++; end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, n, acc, nbad, s0;
    logic [5:0] sacc;

    // Reset and idle
    tick(3);
    chk("rst_start", 32'(motor_start), 32'd0);
    chk("rst_steps", 32'(motor_steps), 32'd0);
    chk("rst_dir",   32'(motor_dir),   32'd0);
    chk("rst_bad",   32'(bad_move),    32'd0);
    chk("rst_md",    32'(moves_done),  32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_ready", 32'(move_ready),  32'd1);
    reset_n = 1'b1;
    sacc = '0;
    repeat (8) begin tick(1); sacc |= motor_start; end
    chk("idle_start", 32'(sacc), 32'd0);
    chk("idle_busy",  32'(busy), 32'd0);

    // Single move F CW: start exactly three cycles after the push cycle
    do_reset();
    push(5'b01001);
    tick(1);
    chk("single_early", 32'(motor_start), 32'd0);
    tick(1);
    chk("single_start", 32'(motor_start), 32'h04);
    chk("single_steps", 32'(motor_steps), 32'd50);
    chk("single_dir",   32'(motor_dir),   32'd0);
    n = 0;
    while (drv_done[2] && n < 10) begin tick(1); n++; end
    n = 0;
    while (!drv_done[2] && n < 200) begin tick(1); n++; end
    chk("single_drv_done", 32'(drv_done[2]), 32'd1);
    chk("single_md_pre", 32'(moves_done), 32'd0);
    tick(1);
    chk("single_md", 32'(moves_done), 32'd1);
    c1 = cyc;
    push(5'b01001);
    wait_start("single_next_to", c2);
    chk("single_gap", 32'(c2 - c1), 32'(GAP + 2));
    wait_md("single_md2", 16'd2, c1);
    wait_idle("single_idle");

    // Turn types: U half then R CCW
    do_reset();
    push(5'b00010);
    push(5'b10111);
    wait_start("turn_u_to", c1);
    chk("turn_u_start", 32'(motor_start), 32'h01);
    chk("turn_u_steps", 32'(motor_steps), 32'd100);
    chk("turn_u_dir",   32'(motor_dir),   32'd0);
    wait_md("turn_md1", 16'd1, c1);
    wait_start("turn_r_to", c2);
    chk("turn_gap",     32'(c2 - c1),     32'(GAP + 2));
    chk("turn_r_start", 32'(motor_start), 32'h20);
    chk("turn_r_steps", 32'(motor_steps), 32'd50);
    chk("turn_r_dir",   32'(motor_dir),   32'd1);
    tick(20);
    chk("turn_r_start_off", 32'(motor_start), 32'd0);
    chk("turn_r_dir_held",  32'(motor_dir),   32'd1);
    chk("turn_r_steps_held", 32'(motor_steps), 32'd50);
    wait_md("turn_md2", 16'd2, c1);
    wait_idle("turn_idle");

    // Invalid codes: face 6, then turn 00
    do_reset();
    push(5'b11001);
    push(5'b00000);
    nbad = 0; sacc = '0;
    repeat (12) begin
      nbad += int'(bad_move);
      sacc |= motor_start;
      tick(1);
    end
    chk("bad_pulses", 32'(nbad), 32'd2);
    chk("bad_start",  32'(sacc), 32'd0);
    chk("bad_md",     32'(moves_done), 32'd0);
    chk("bad_busy",   32'(busy), 32'd0);

    // Full and flush with a stalled driver
    do_reset();
    stall = 1'b1;
    push(5'b01001);
    wait_start("full_first_to", c1);
    acc = 0;
    for (int i = 0; i < 17; i++) begin
      move_valid = 1'b1;
      move_data  = 5'b10001;
      if (move_ready) acc++;
      tick(1);
    end
    move_valid = 1'b0;
    chk("full_accepted", 32'(acc), 32'd16);
    chk("full_ready",    32'(move_ready), 32'd0);
    chk("full_busy",     32'(busy), 32'd1);
    s0 = nstart;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("flush_ready", 32'(move_ready), 32'd1);
    stall = 1'b0;
    wait_idle("flush_idle");
    chk("flush_md",     32'(moves_done), 32'd1);
    chk("flush_starts", 32'(nstart - s0), 32'd0);

    // Reset in RUN drops the move; a fresh push starts normally
    do_reset();
    push(5'b10101);
    wait_md("mid_md1", 16'd1, c1);
    push(5'b00011);
    wait_start("mid_start_to", c1);
    tick(10);
    chk("mid_busy_pre", 32'(busy), 32'd1);
    reset_n = 1'b0;
    tick(1);
    chk("mid_rst_start", 32'(motor_start), 32'd0);
    chk("mid_rst_steps", 32'(motor_steps), 32'd0);
    chk("mid_rst_dir",   32'(motor_dir),   32'd0);
    chk("mid_rst_busy",  32'(busy),        32'd0);
    chk("mid_rst_md",    32'(moves_done),  32'd0);
    chk("mid_rst_ready", 32'(move_ready),  32'd1);
    reset_n = 1'b1;
    push(5'b01011);
    tick(2);
    chk("mid_new_start", 32'(motor_start), 32'h04);
    chk("mid_new_steps", 32'(motor_steps), 32'd50);
    chk("mid_new_dir",   32'(motor_dir),   32'd1);
    wait_md("mid_new_md", 16'd1, c1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
